// File: rtl/display_pkg.sv
// Shared seven-segment constants for the clock displays.
// All display pins are active-low.
package display_pkg;

  localparam logic SEG_ACTIVE   = 1'b0;
  localparam logic ANODE_ACTIVE = 1'b0;
  localparam logic DP_OFF       = 1'b1;

  localparam logic [3:0] ANODES_OFF = 4'b1111;

  // Segment order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low seven-segment pattern.
// Values above 9 show a dash.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/time_display.sv
// Four-digit multiplexed display driver: per-frame snapshot of the BCD time bus,
// blanked digit scan, leading-zero suppression, PM dot and optional blink.
module time_display
  import display_pkg::*;
#(
  parameter int DIGIT_PERIOD = 5000,
  parameter int BLANK_CYCLES = 250,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        i_Clk,
  input  logic        i_Reset_n,
  input  logic [15:0] i_Time,
  input  logic        i_PM,
  input  logic        i_Blink_En,
  output logic [6:0]  o_Segments,
  output logic        o_DP,
  output logic [3:0]  o_Anodes
);

  localparam int P_W   = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [P_W-1:0]   P_LAST   = P_W'(DIGIT_PERIOD - 1);
  localparam logic [P_W-1:0]   P_BLANK  = P_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [P_W-1:0]   p;
  logic [1:0]       d;
  logic [16:0]      snap;
  logic             snap_valid;
  logic             blink_en_q;
  logic [CNT_W-1:0] blink_cnt;
  logic             phase;
  logic             frame_start;
  logic [3:0]       nibble;
  logic [6:0]       seg_dec;
  logic             lit;
  logic [3:0]       anode_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  assign frame_start = (p == P_LAST) && (d == 2'd3);

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      p <= P_LAST;
      d <= 2'd3;
    end else if (p == P_LAST) begin
      p <= '0;
      d <= d + 2'd1;
    end else begin
      p <= p + P_W'(1);
    end
  end

  // Blink phase only advances across consecutive enabled frames, so the
  // first enabled frame is always visible.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      snap       <= '0;
      snap_valid <= 1'b0;
      blink_en_q <= 1'b0;
      blink_cnt  <= '0;
      phase      <= 1'b1;
    end else if (frame_start) begin
      snap       <= {i_PM, i_Time};
      snap_valid <= 1'b1;
      blink_en_q <= i_Blink_En;
      if (!i_Blink_En || !blink_en_q) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (blink_cnt == CNT_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd (nibble),
    .seg (seg_dec)
  );

  // snap_valid keeps the tail of the reset-state slot (d=3) dark.
  always_comb begin
    nibble = snap[3:0];
    case (d)
      2'd0: nibble = snap[3:0];
      2'd1: nibble = snap[7:4];
      2'd2: nibble = snap[11:8];
      2'd3: nibble = snap[15:12];
      default: nibble = snap[3:0];
    endcase

    lit       = snap_valid && (p >= P_BLANK) && !(blink_en_q && !phase);
    anode_nxt = ANODES_OFF;
    seg_nxt   = SEG_OFF;
    dp_nxt    = DP_OFF;
    if (lit) begin
      anode_nxt[d] = ANODE_ACTIVE;
      seg_nxt      = ((d == 2'd3) && (nibble == 4'd0)) ? SEG_OFF : seg_dec;
      if ((d == 2'd0) && snap[16]) dp_nxt = SEG_ACTIVE;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Anodes   <= ANODES_OFF;
      o_Segments <= SEG_OFF;
      o_DP       <= DP_OFF;
    end else begin
      o_Anodes   <= anode_nxt;
      o_Segments <= seg_nxt;
      o_DP       <= dp_nxt;
    end
  end

endmodule

// File: doc/time_display.md
# time_display

Four-digit multiplexed seven-segment driver for the alarm clock; it is the consumer end of the packed BCD time bus (`{hours tens, hours units, minutes tens, minutes units}` plus PM flag) produced by the timekeeping block. It snapshots the bus once per scan frame so digits never tear. It scans one digit at a time with an anti-ghosting blank interval, blanks a leading hours zero, lights the PM dot, and optionally blinks the whole display while time is being set. It sits between the time/alarm selection logic and the board's common-anode display pins.

## Interface
- `DIGIT_PERIOD`, default 5000: clock cycles per digit slot (1 kHz per digit at 5 MHz; 250 Hz frame).
- `BLANK_CYCLES`, default 250: cycles at the start of each slot with all anodes off; must be < `DIGIT_PERIOD`.
- `BLINK_FRAMES`, default 125: frames per blink half-period (0.5 s at defaults).
- `i_Clk`, in, 1: single clock, 5 MHz.
- `i_Reset_n`, in, 1: asynchronous, active-low reset.
- `i_Time`, in, 16: packed BCD digits as above.
- `i_PM`, in, 1: PM indicator.
- `i_Blink_En`, in, 1: level; blink the display while high.
- `o_Segments`, out, 7: `{g,f,e,d,c,b,a}`, active-low.
- `o_DP`, out, 1: decimal point, active-low.
- `o_Anodes`, out, 4: digit enables, active-low; bit 0 is the rightmost digit (minutes units), bit 3 is hours tens.

## Operation
- **Prescaler** `p` counts 0..`DIGIT_PERIOD`-1 and wraps.
  - On wrap, digit index `d` advances 0→1→2→3→0.
  - Reset state is `p`=`DIGIT_PERIOD`-1, `d`=3, so the first clock edge after reset release starts a frame.
- **Frame start** is the edge where `d` goes 3→0.
  - The snapshot register captures `{i_PM, i_Time}` on this edge.
  - The snapshot resets to 0.
  - Input changes at any other time are invisible until the next frame start.
- **Blink:**
  - A frame counter counts frames; every `BLINK_FRAMES` frames it toggles `phase` (1 = visible).
  - While `i_Blink_En`=0, the counter is held at 0 and `phase`=1, so blinking always starts visible.
  - `i_Blink_En` is sampled only at frame start; a change mid-frame takes effect next frame.
- **Per slot:**
  - Anodes are all off while `p` < `BLANK_CYCLES`, or when `i_Blink_En` and `phase`=0.
  - Otherwise `o_Anodes[d]`=0.
- **Segment decode** of snapshot nibble `d`:
  - 0–9 use standard patterns (0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 5=7'b0010010, 8=7'b0000000).
  - 10–15 show a dash (7'b0111111).
- **Leading zero:** when `d`=3 and the nibble is 0, segments are all off (7'b1111111); the anode is still driven.
- **Decimal point:** `o_DP`=0 only when `d`=0 and the snapshot PM bit is 1; otherwise 1.
- **Segment/DP during blanking:** segment and DP values during blank cycles are don't-care at the pins. They shall be driven all-off (1) so the bench can check them.

## Timing
- **Outputs:** all outputs are registered, with 1-cycle latency from the `p`/`d` state to the pins.
- **Reset values:** `o_Anodes`=4'b1111, `o_Segments`=7'b1111111, `o_DP`=1.
- **Reset mid-operation:** assertion clears everything immediately (asynchronous). After release:
  - The first edge captures the snapshot.
  - The first anode is lit `BLANK_CYCLES`+1 cycles after that edge.
- **Slot length:** each digit slot lasts exactly `DIGIT_PERIOD` cycles, of which `DIGIT_PERIOD`-`BLANK_CYCLES` are lit. No two anodes are ever low in the same cycle.
- **Simultaneous events:** an input change on the frame-start edge itself is captured with the pre-edge value, per normal register semantics.
- **Counter widths:**
  - `p`: `$clog2(DIGIT_PERIOD)`.
  - Blink counter: `$clog2(BLINK_FRAMES)`.
  - `d`: 2 bits.

## Structure
- **Shared package `display_pkg`:** segment constants (`SEG_OFF`, `SEG_DASH`, digit patterns 0–9) and the anode/segment active-low polarity constants.
- **Sub-module `bcd_to_7seg`:** 4-bit in, 7-bit active-low out, dash for values above 9; reused later by the alarm-setting display.
- **Top level:** prescaler, digit counter, snapshot register, blink counter and output registers.

## Test plan
All scenarios use `DIGIT_PERIOD`=8, `BLANK_CYCLES`=2, `BLINK_FRAMES`=2.

1. **Reset state:** hold `i_Reset_n`=0 with `i_Time`=16'h1234 → outputs stay at reset values. After release, frame shows digits 4,3,2,1 on anodes 1110,1101,1011,0111, each lit 6 of 8 cycles with 2 blank cycles first.
2. **Leading zero and PM:** `i_Time`=16'h0945, `i_PM`=1 → `d`=3 slot has all segments off with anode 0111 low; `o_DP`=0 only during the `d`=0 lit cycles.
3. **Snapshot/no tearing:** change `i_Time` from 16'h1159 to 16'h1200 mid-frame (during `d`=1) → remainder of frame shows 1159; next frame shows 1200.
4. **Invalid BCD:** `i_Time`=16'h12AF → `d`=0 and `d`=1 slots show 7'b0111111.
5. **Blink:** assert `i_Blink_En` → 2 frames lit, 2 frames all anodes 1111, repeating. Deassert `i_Blink_En` during a dark frame → display lit from the next frame start.
6. **Reset mid-frame:** assert `i_Reset_n`=0 during the `d`=2 lit period → anodes go 1111 in the same cycle (asynchronous). After release, scan restarts at `d`=0 with a fresh snapshot.
